// File: rtl/rect_cmd_sequencer.sv
// Rectangle command sequencer: queues draw commands in a small FIFO and hands them to the
// renderer one at a time with an enable/done handshake and a fixed idle gap between draws.
module rect_cmd_sequencer #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int C_W      = 3,
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int GAP      = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [X_W-1:0]             cmd_x,
  input  logic [Y_W-1:0]             cmd_y,
  input  logic [X_W-1:0]             cmd_w,
  input  logic [Y_W-1:0]             cmd_h,
  input  logic [C_W-1:0]             cmd_back,
  input  logic                       cmd_border,
  input  logic [C_W-1:0]             cmd_border_color,
  input  logic                       flush,
  output logic                       rect_enable,
  output logic [X_W-1:0]             rect_x,
  output logic [Y_W-1:0]             rect_y,
  output logic [X_W-1:0]             rect_w,
  output logic [Y_W-1:0]             rect_h,
  output logic [C_W-1:0]             rect_back,
  output logic                       rect_border,
  output logic [C_W-1:0]             rect_border_color,
  input  logic                       rect_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drawn_count,
  output logic                       err_drop,
  output logic [1:0]                 dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CW    = 2 * X_W + 2 * Y_W + 2 * C_W + 1;
  localparam int GCW   = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [CW-1:0]   rect_q, rect_d;
  logic            en_q, en_d, armed_q, armed_d, err_q, err_d;
  logic [GCW-1:0]  gap_q, gap_d;
  logic [15:0]     drawn_q, drawn_d;
  logic            push, pop, bad_rect;

  // Command port is valid/ready: a word transfers on any edge where cmd_valid & cmd_ready,
  // unless flush is high in that cycle (the word is then discarded along with the queue).
  assign cmd_ready = (count_q != LVL_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready & ~flush;
  assign pop       = (state_q == S_IDLE) & (count_q != '0) & ~flush;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_border_color};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + LVL_W'(1);
      else if (!push && pop) count_d = count_q - LVL_W'(1);
    end
  end

  assign {rect_x, rect_y, rect_w, rect_h, rect_back, rect_border, rect_border_color} = rect_q;
  assign bad_rect = (rect_w == '0) | (rect_h == '0) |
                    (rect_x >= X_W'(SCREEN_W)) | (rect_y >= Y_W'(SCREEN_H));

  always_comb begin
    state_d = state_q;
    rect_d  = rect_q;
    en_d    = en_q;
    armed_d = armed_q;
    gap_d   = gap_q;
    drawn_d = drawn_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rect_d  = mem_q[rd_ptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bad_rect) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          en_d    = 1'b1;
          armed_d = 1'b0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        // The renderer reports done=1 before its first write; only trust done after a 0.
        if (!rect_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          en_d    = 1'b0;
          drawn_d = drawn_q + 16'd1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GCW'(GAP - 1)) state_d = S_IDLE;
        else                        gap_d   = gap_q + GCW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rect_q   <= '0;
      en_q     <= 1'b0;
      armed_q  <= 1'b0;
      gap_q    <= '0;
      drawn_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rect_q   <= rect_d;
      en_q     <= en_d;
      armed_q  <= armed_d;
      gap_q    <= gap_d;
      drawn_q  <= drawn_d;
      err_q    <= err_d;
    end
  end

  assign rect_enable = en_q;
  assign busy        = (state_q != S_IDLE) | (count_q != '0);
  assign level       = count_q;
  assign drawn_count = drawn_q;
  assign err_drop    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Directed and randomized bench for rect_cmd_sequencer with a renderer model and an
// in-order scoreboard of the commands expected to reach the renderer.
module tb_rect_cmd_sequencer;

  localparam int X_W = 9, Y_W = 8, C_W = 3, DEPTH = 8;
  localparam int CW  = 2 * X_W + 2 * Y_W + 2 * C_W + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [X_W-1:0] cmd_x = '0, cmd_w = '0;
  logic [Y_W-1:0] cmd_y = '0, cmd_h = '0;
  logic [C_W-1:0] cmd_back = '0, cmd_border_color = '0;
  logic cmd_border = 1'b0, flush = 1'b0;
  logic rect_enable, rect_border, rect_done = 1'b0, busy, err_drop;
  logic [X_W-1:0] rect_x, rect_w;
  logic [Y_W-1:0] rect_y, rect_h;
  logic [C_W-1:0] rect_back, rect_border_color;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] drawn_count;
  logic [1:0] dbg_state;

  always #10 clk = ~clk;

  rect_cmd_sequencer dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_back(cmd_back),
    .cmd_border(cmd_border), .cmd_border_color(cmd_border_color), .flush(flush),
    .rect_enable(rect_enable), .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w),
    .rect_h(rect_h), .rect_back(rect_back), .rect_border(rect_border),
    .rect_border_color(rect_border_color), .rect_done(rect_done), .busy(busy),
    .level(level), .drawn_count(drawn_count), .err_drop(err_drop), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];
  int   exp_drawn = 0;
  logic exp_err = 1'b0;
  int   rise_cnt = 0;
  int   render_lat = 150;
  bit   render_stall = 1'b0;
  bit   force_done = 1'b0;

  wire [CW-1:0] rect_bus = {rect_x, rect_y, rect_w, rect_h, rect_back, rect_border, rect_border_color};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int x, input int y, input int w, input int h,
                                       input int b, input int bd, input int bc);
    return {X_W'(x), Y_W'(y), X_W'(w), Y_W'(h), C_W'(b), 1'(bd), C_W'(bc)};
  endfunction

  // A command reaches the renderer only if it has area and its origin lies on the 320x240 screen.
  function automatic bit cmd_ok(input logic [CW-1:0] c);
    int x, y, w, h;
    x = int'(c[40:32]); y = int'(c[31:24]); w = int'(c[23:15]); h = int'(c[14:7]);
    return (w != 0) && (h != 0) && (x < 320) && (y < 240);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [CW-1:0] c);
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_border_color} = c;
    cmd_valid = 1'b1;
  endtask

  task automatic push_cmd(input logic [CW-1:0] c);
    int n = 0;
    drive_cmd(c);
    while (!cmd_ready && n < 3000) begin step(); n++; end
    if (!cmd_ready) begin
      check("push_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    if (cmd_ok(c)) begin exp_q.push_back(c); exp_drawn++; end
    else exp_err = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || rect_enable) && n < budget) begin step(); n++; end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!rect_enable && n < budget) begin step(); n++; end
    check("enable_timeout", 64'(rect_enable), 64'd1);
  endtask

  function automatic logic [CW-1:0] rand_cmd();
    int mode = $urandom_range(0, 9);
    int x = $urandom_range(0, 319), y = $urandom_range(0, 239);
    int w = $urandom_range(1, 511), h = $urandom_range(1, 255);
    case (mode)
      0: w = 0;
      1: h = 0;
      2: x = $urandom_range(320, 511);
      3: y = $urandom_range(240, 255);
      default: ;
    endcase
    return mk(x, y, w, h, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
  endfunction

  // Renderer model and draw monitor: done goes 1 after render_lat enabled cycles.
  initial begin
    int cnt = 0;
    logic prev_en = 1'b0;
    logic [CW-1:0] cap = '0;
    forever begin
      @(negedge clk);
      if (rect_enable && !prev_en) begin
        rise_cnt++;
        if (exp_q.size() == 0) check("unexpected_draw", 64'd1, 64'd0);
        else begin
          cap = exp_q.pop_front();
          check("attrs_at_enable", 64'(rect_bus), 64'(cap));
        end
      end else if (rect_enable && prev_en) begin
        check("attrs_stable", 64'(rect_bus), 64'(cap));
      end
      if (!rect_enable) begin cnt = 0; rect_done = force_done; end
      else if (force_done) rect_done = 1'b1;
      else if (render_stall) rect_done = 1'b0;
      else begin cnt++; rect_done = (cnt > render_lat); end
      prev_en = rect_enable;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c;
    int r0, d0;

    // Reset values
    resetn = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_enable", 64'(rect_enable), 64'd0);
    check("rst_attrs", 64'(rect_bus), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drawn", 64'(drawn_count), 64'd0);
    check("rst_err", 64'(err_drop), 64'd0);
    resetn = 1'b1;
    step();

    // Single command: enable rises two edges after the accepting edge
    render_lat = 150;
    c = mk(10, 20, 30, 5, 3, 1, 7);
    push_cmd(c);
    check("t1_en_after_push", 64'(rect_enable), 64'd0);
    step();
    check("t1_en_after_pop", 64'(rect_enable), 64'd0);
    check("t1_level_after_pop", 64'(level), 64'd0);
    step();
    check("t1_en_rises", 64'(rect_enable), 64'd1);
    check("t1_attrs", 64'(rect_bus), 64'(c));
    wait_idle(400);
    check("t1_drawn", 64'(drawn_count), 64'd1);
    check("t1_en_low", 64'(rect_enable), 64'd0);

    // FIFO full while the renderer stalls; the extra command waits for a pop
    render_lat = 5;
    render_stall = 1'b1;
    push_cmd(mk(1, 2, 3, 4, 5, 0, 6));
    wait_en(20);
    for (int i = 0; i < DEPTH; i++) push_cmd(mk(i * 7, i * 3 + 1, i + 1, 2 * i + 1, i, i % 2, 7 - i));
    check("t2_ready_full", 64'(cmd_ready), 64'd0);
    check("t2_level_full", 64'(level), 64'(DEPTH));
    c = mk(200, 100, 50, 40, 2, 1, 1);
    drive_cmd(c);
    repeat (4) step();
    check("t2_level_held", 64'(level), 64'(DEPTH));
    render_stall = 1'b0;
    push_cmd(c);
    wait_idle(3000);
    check("t2_drawn", 64'(drawn_count), 64'(exp_drawn));
    check("t2_all_drawn", 64'(exp_q.size()), 64'd0);

    // Dropped commands, including the exact screen boundaries
    check("t3_err_clear", 64'(err_drop), 64'd0);
    r0 = rise_cnt;
    push_cmd(mk(5, 5, 0, 10, 1, 0, 1));
    push_cmd(mk(5, 5, 10, 0, 1, 0, 1));
    push_cmd(mk(320, 5, 10, 10, 1, 0, 1));
    push_cmd(mk(5, 240, 10, 10, 1, 0, 1));
    push_cmd(mk(319, 239, 1, 1, 4, 1, 2));
    wait_idle(500);
    check("t3_one_draw", 64'(rise_cnt - r0), 64'd1);
    check("t3_err_set", 64'(err_drop), 64'(exp_err));
    push_cmd(mk(0, 0, 8, 8, 6, 0, 0));
    wait_idle(500);
    check("t3_err_sticky", 64'(err_drop), 64'd1);
    check("t3_drawn", 64'(drawn_count), 64'(exp_drawn));

    // done held high before the renderer starts must not complete the draw
    force_done = 1'b1;
    d0 = exp_drawn;
    push_cmd(mk(40, 40, 20, 20, 1, 1, 3));
    wait_en(20);
    repeat (10) step();
    check("t4_en_held", 64'(rect_enable), 64'd1);
    check("t4_no_complete", 64'(drawn_count), 64'(d0));
    force_done = 1'b0;
    wait_idle(500);
    check("t4_complete", 64'(drawn_count), 64'(d0 + 1));

    // Flush during a draw discards only the queued commands
    render_lat = 30;
    push_cmd(mk(1, 1, 9, 9, 1, 0, 0));
    push_cmd(mk(2, 2, 9, 9, 2, 0, 0));
    push_cmd(mk(3, 3, 9, 9, 3, 0, 0));
    wait_en(20);
    step();
    check("t5_level_before", 64'(level), 64'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_drawn -= exp_q.size();
    exp_q.delete();
    check("t5_level_flushed", 64'(level), 64'd0);
    check("t5_draw_continues", 64'(rect_enable), 64'd1);
    wait_idle(500);
    check("t5_drawn", 64'(drawn_count), 64'(exp_drawn));

    // Asynchronous reset in the middle of a draw
    render_lat = 100;
    push_cmd(mk(50, 60, 70, 80, 5, 1, 2));
    push_cmd(mk(51, 61, 71, 81, 6, 0, 3));
    wait_en(20);
    repeat (5) step();
    #3;
    resetn = 1'b0;
    #1;
    check("t6_en_async", 64'(rect_enable), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_drawn", 64'(drawn_count), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_err", 64'(err_drop), 64'd0);
    check("t6_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    exp_drawn = 0;
    exp_err = 1'b0;
    step();
    resetn = 1'b1;
    step();
    render_lat = 4;
    push_cmd(mk(100, 100, 10, 10, 7, 1, 7));
    wait_idle(200);
    check("t6_resume", 64'(drawn_count), 64'd1);

    // Randomized traffic with random renderer latency
    for (int i = 0; i < 60; i++) begin
      render_lat = $urandom_range(1, 12);
      push_cmd(rand_cmd());
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(5000);
    check("rand_drawn", 64'(drawn_count), 64'(exp_drawn));
    check("rand_err", 64'(err_drop), 64'(exp_err));
    check("rand_all_drawn", 64'(exp_q.size()), 64'd0);
    check("rand_level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
